packet_source: RTL
==================

// Module: packet_source
// PURPOSE
//  Per-port traffic generator feeding the network input; the counterpart of the per-port packet sink.
//  Injects packets by Bernoulli trial against a programmable rate, picks a pseudo-random destination,
//  stamps generation time into data[15:0] and queues them in a source FIFO so measured latency includes
//  source queueing. Drains the FIFO toward the network under a valid/ready handshake.
// PARAMETERS
//  PORT_NO      0       this source's port index
//  N_PORTS      8       number of network ports (>=2); dest range 0..N_PORTS-1
//  FIFO_DEPTH   16      source queue entries (power of 2, >=2)
//  SEED         16'hACE1 LFSR reset value (must be non-zero)
//  EXCLUDE_SELF 1       1: never address PORT_NO
// PORTS
//  clk         in   1        clock
//  rst         in   1        reset, synchronous, active-high
//  enable      in   1        injection enable (draining continues when low)
//  rate        in   16       injection threshold; inject when lfsr <= rate
//  timestamp   in   16       free-running global time, shared with sinks
//  pkt_ready   in   1        network accepts pkt_tx this cycle
//  pkt_tx      out  packet_t head of FIFO: valid, dest, data
//  pkt_count   out  16       packets accepted by network (wraps)
//  drop_count  out  16       generated packets lost to full FIFO (saturates at 16'hFFFF)
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset: lfsr<=SEED, FIFO empty, seq<=0, pkt_tx.valid=0, pkt_count=0, drop_count=0, fifo_level=0.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every non-reset cycle irrespective of enable.
//  Generate (gen) in cycle t when enable && lfsr<=rate, using lfsr value of cycle t:
//   rate=0 -> never (lfsr never 0); rate=16'hFFFF -> every cycle.
//   d = lfsr[15:8] % N_PORTS; if EXCLUDE_SELF && d==PORT_NO then d=(d+1)%N_PORTS.
//   entry: dest=d, data[15:0]=timestamp (cycle t), data[31:16]=seq, other data bits 0.
//  Push: gen && (!full || pop); entry visible at pkt_tx the following cycle (1-cycle latency when empty).
//   seq increments only on push (wraps at 16'hFFFF->0); no gap in accepted sequence numbers.
//  Drop: gen && full && !pop -> entry discarded, drop_count+1 (saturating), seq unchanged.
//  Output: pkt_tx = FIFO head (registered storage read); pkt_tx.valid = !empty.
//  Handshake: pop when pkt_tx.valid && pkt_ready at posedge; pkt_count+1 on pop.
//   While valid && !pkt_ready, pkt_tx held stable (dest, data unchanged).
//   pkt_ready while empty: ignored, no count change.
//  Simultaneous push+pop: occupancy unchanged, allowed at full and at empty(+0 only if non-empty).
//   Empty FIFO: push bypass not allowed; gen while empty appears next cycle, never same cycle.
//  fifo_level: 0..FIFO_DEPTH, = pushes - pops since reset.
//  Pointers: wrap modulo FIFO_DEPTH; full/empty from extra-bit pointer compare.
//  Reset mid-operation: FIFO contents discarded, counters cleared, lfsr reseeded next cycle.
//  enable low: no generation; queued packets still drain; enable mid-cycle takes effect same cycle.
// TESTING
//  1 rate=16'hFFFF, enable=1, pkt_ready=1 constant -> pkt_tx.valid from cycle 2, one pkt/cycle,
//    data[31:16]=0,1,2..., data[15:0]=timestamp-1 at output, drop_count=0, fifo_level<=1.
//  2 rate=16'hFFFF, pkt_ready=0 for 20 cycles (FIFO_DEPTH=16) -> fifo_level=16, drop_count=4,
//    pkt_tx held at seq 0; then ready=1 -> seq 0..15 emitted in order, seq continues 16 with no gap.
//  3 rate=0 for 1000 cycles -> pkt_tx.valid stays 0, pkt_count=0, drop_count=0.
//  4 N_PORTS=4, PORT_NO=2, EXCLUDE_SELF=1, rate=16'hFFFF, 10000 pkts -> dest never 2,
//    each of 0,1,3 seen; golden LFSR model from SEED matches every dest.
//  5 full FIFO, gen and pop same cycle -> no drop, level stays 16, pkt_count+1.
//  6 rst asserted for 1 cycle with level=9 -> next cycle valid=0, level=0, counters 0, first
//    subsequent packet seq=0; rate=16'h8000 run 65535 cycles -> pkt_count+drop ~= 32768 (exact vs model).

Source files
------------

// File: rtl/pkt_if.sv
// Packet handshake bundle between a traffic source and the network input.
// The source drives valid/dest/data and the network answers with ready.
interface pkt_if #(
  parameter int N_PORTS = 8
);
  localparam int DEST_W = $clog2(N_PORTS);

  logic              valid;
  logic [DEST_W-1:0] dest;
  logic [31:0]       data;
  logic              ready;

  modport master (output valid, output dest, output data, input ready);
  modport slave  (input valid, input dest, input data, output ready);
endinterface

// File: rtl/packet_source.sv
// Per-port traffic generator: Bernoulli injection against an LFSR, pseudo-random
// destination, timestamped entries queued in a source FIFO drained under valid/ready.
module packet_source #(
  parameter int          PORT_NO      = 0,
  parameter int          N_PORTS      = 8,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter bit          EXCLUDE_SELF = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [15:0]                   rate,
  input  logic [15:0]                   timestamp,
  pkt_if.master                         pkt_tx,
  output logic [15:0]                   pkt_count,
  output logic [15:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int DEST_W  = $clog2(N_PORTS);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = DEST_W + 32;
  localparam logic [8:0] NP = 9'(N_PORTS);
  localparam logic [8:0] PN = 9'(PORT_NO);

  logic [15:0]        lfsr;
  logic [15:0]        seq;
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

  logic               full;
  logic               empty;
  logic               gen;
  logic               push;
  logic               pop;
  logic               drop;
  logic [8:0]         d_mod;
  logic [8:0]         d_sel;
  logic [DEST_W-1:0]  gen_dest;

  // Destination from the upper LFSR byte; self-addressing bumps to the next port.
  assign d_mod = {1'b0, lfsr[15:8]} % NP;

  always_comb begin
    d_sel = d_mod;
    if (EXCLUDE_SELF && (d_mod == PN)) begin
      d_sel = (d_mod + 9'd1) % NP;
    end
  end

  assign gen_dest = d_sel[DEST_W-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign gen  = enable && (lfsr <= rate);
  assign pop  = !empty && pkt_tx.ready;
  // A pop frees the slot this same edge, so a full queue can still accept.
  assign push = gen && (!full || pop);
  assign drop = gen && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= SEED;
      seq        <= 16'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_count  <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 16'd1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        pkt_count <= pkt_count + 16'd1;
      end
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr[AW-1:0]] <= {gen_dest, seq, timestamp};
    end
  end

  // Head read straight from storage: no bypass, so a push into an empty queue shows next cycle.
  assign pkt_tx.valid             = !empty;
  assign {pkt_tx.dest, pkt_tx.data} = mem[rd_ptr[AW-1:0]];
  assign fifo_level               = wr_ptr - rd_ptr;

endmodule
